// File: rtl/fsk_if.sv
// Serial-bit input and shaped frequency-word output bundle for the FSK shaper.
interface fsk_if #(
    parameter int FW = 12
);
    logic                 en;
    logic                 tx;
    logic                 tx_valid;
    logic signed [FW-1:0] freq_word;
    logic                 mod_active;
    logic                 busy;

    modport master (output en, tx, tx_valid, input freq_word, mod_active, busy);
    modport slave  (input en, tx, tx_valid, output freq_word, mod_active, busy);
endinterface

// File: rtl/fsk_shaper.sv
// Box-filter shaping of a whitened serial bit stream into a signed DCO deviation word,
// with PA gating that stays up until the filter has fully drained after the last bit.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  S_IDLE   | no packet; symbol input is 0, PA off
//  S_ACTIVE | packet in progress; held symbol re-enters the filter each sample
//  S_DRAIN  | strobes stopped; zeros are fed until the window empties
module fsk_shaper #(
    parameter int FILT_LEN = 8,
    parameter int DEV_STEP = 16,
    parameter int FW       = 12,
    parameter int GAP_MAX  = 16
) (
    input  logic clk,
    input  logic rst,
    fsk_if.slave bus
);
    localparam int AW = $clog2(FILT_LEN) + 2;
    localparam int GW = $clog2(GAP_MAX);
    localparam int DW = $clog2(FILT_LEN);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    localparam logic [GW-1:0]        GAP_LAST   = GW'(GAP_MAX - 1);
    localparam logic [DW-1:0]        DRAIN_LOAD = DW'(FILT_LEN - 1);
    localparam logic signed [FW-1:0] DEV_K      = FW'(DEV_STEP);

    logic [1:0]           state, state_nxt;
    logic signed [1:0]    sym, cur;
    logic signed [1:0]    dl [FILT_LEN];
    logic signed [AW-1:0] acc, acc_nxt, cur_ext, tail_ext;
    logic signed [FW-1:0] acc_ext;
    logic [GW-1:0]        gap_cnt;
    logic [DW-1:0]        drain_cnt;
    logic                 mod_active_r;

    always_comb begin
        cur = 2'sd0;
        if (bus.tx_valid)
            cur = bus.tx ? 2'sd1 : -2'sd1;
        else if (state == S_ACTIVE)
            cur = sym;
    end

    // Running sum: add the entering symbol, remove the one leaving the window
    assign cur_ext  = {{(AW-2){cur[1]}}, cur};
    assign tail_ext = {{(AW-2){dl[FILT_LEN-1][1]}}, dl[FILT_LEN-1]};
    assign acc_nxt  = acc + cur_ext - tail_ext;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.tx_valid)
                    state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!bus.tx_valid && gap_cnt == GAP_LAST)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.tx_valid)
                    state_nxt = S_ACTIVE;
                else if (drain_cnt == '0 && acc == '0)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            sym          <= 2'sd0;
            acc          <= '0;
            gap_cnt      <= '0;
            drain_cnt    <= '0;
            mod_active_r <= 1'b0;
            for (int i = 0; i < FILT_LEN; i++)
                dl[i] <= 2'sd0;
        end else if (bus.en) begin
            state        <= state_nxt;
            mod_active_r <= (state_nxt != S_IDLE);
            acc          <= acc_nxt;
            dl[0]        <= cur;
            for (int i = FILT_LEN - 1; i > 0; i--)
                dl[i] <= dl[i-1];
            if (bus.tx_valid)
                sym <= cur;

            if (bus.tx_valid)
                gap_cnt <= '0;
            else if (state == S_ACTIVE && gap_cnt != GAP_LAST)
                gap_cnt <= gap_cnt + GW'(1);

            // Leaving ACTIVE on a gap timeout also drops the held symbol
            if (state == S_ACTIVE && state_nxt == S_DRAIN) begin
                sym       <= 2'sd0;
                drain_cnt <= DRAIN_LOAD;
            end else if (state == S_DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DW'(1);
            end
        end
    end

    assign acc_ext        = {{(FW-AW){acc[AW-1]}}, acc};
    assign bus.freq_word  = acc_ext * DEV_K;
    assign bus.mod_active = mod_active_r;
    assign bus.busy       = mod_active_r;
endmodule
